button_menu_ctrl: RTL and testbench

BUTTON_MENU_CTRL -- requirements
Module: button_menu_ctrl

---
 rtl/menu_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 48 ++++
 rtl/button_menu_ctrl.sv | 93 +++++++++
 tb/tb_button_menu_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/menu_pkg.sv
// Shared types and constants for the push-button menu controller:
// FSM state encoding, default parameters and the hex-to-7-segment table.
package menu_pkg;

    typedef enum logic {
        BROWSE = 1'b0,
        DONE   = 1'b1
    } menu_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_NUM_OPTIONS     = 4;

    // Active-low segments, bit 0 = segment a, bit 6 = segment g.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, consecutive-cycle debouncer
// and a registered rising-edge detector producing a single-cycle press pulse.
module btn_debounce
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // The count only advances while the synchronized input disagrees with the
    // debounced level; a single agreeing cycle starts the qualification over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_q <= level;
            pulse   <= level & ~level_q;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_menu_ctrl.sv
// Three-button menu controller: browse a wrapping list of entries with up/down,
// commit or release the highlighted entry with select, and show it on a 7-seg digit.
module button_menu_ctrl
    import menu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int NUM_OPTIONS     = DEFAULT_NUM_OPTIONS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           up_btn,
    input  logic                           down_btn,
    input  logic                           select_btn,
    output logic [$clog2(NUM_OPTIONS)-1:0] sel_index,
    output logic                           selection_done,
    output logic                           mode,
    output logic                           commit_pulse,
    output logic [6:0]                     seg_idx
);

    localparam int IDX_W = $clog2(NUM_OPTIONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPTIONS - 1);

    logic up_p;
    logic down_p;
    logic select_p;

    menu_state_t      state;
    menu_state_t      state_next;
    logic [IDX_W-1:0] sel_next;
    logic             mode_next;
    logic             commit_next;
    logic [6:0]       seg_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk(clk), .rst(rst), .btn(up_btn), .pulse(up_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk(clk), .rst(rst), .btn(down_btn), .pulse(down_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_select (
        .clk(clk), .rst(rst), .btn(select_btn), .pulse(select_p)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= BROWSE;
            sel_index    <= '0;
            mode         <= 1'b0;
            commit_pulse <= 1'b0;
            seg_idx      <= 7'b1000000;
        end else begin
            state        <= state_next;
            sel_index    <= sel_next;
            mode         <= mode_next;
            commit_pulse <= commit_next;
            seg_idx      <= seg_next;
        end
    end

    // Select wins over up/down, so a commit always captures the pre-update index.
    always_comb begin
        state_next  = state;
        sel_next    = sel_index;
        mode_next   = mode;
        commit_next = 1'b0;
        seg_next    = hex_to_seg(4'(sel_index));
        case (state)
            BROWSE: begin
                if (select_p) begin
                    state_next  = DONE;
                    mode_next   = sel_index[0];
                    commit_next = 1'b1;
                end else if (up_p && !down_p) begin
                    sel_next = (sel_index == LAST_IDX) ? '0 : sel_index + IDX_W'(1);
                end else if (down_p && !up_p) begin
                    sel_next = (sel_index == '0) ? LAST_IDX : sel_index - IDX_W'(1);
                end
            end
            DONE: begin
                if (select_p) begin
                    state_next = BROWSE;
                end
            end
            default: state_next = BROWSE;
        endcase
    end

    assign selection_done = (state == DONE);

endmodule

// File: tb/tb_button_menu_ctrl.sv
// Randomized self-checking bench for button_menu_ctrl with a window-based
// behavioural model of the button chains and the menu, plus pinned literal checks.
module tb_button_menu_ctrl;

    localparam int D = 4;
    localparam int N = 4;
    localparam int W = $clog2(N);

    localparam logic [6:0] SEG_REF [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         up_btn = 1'b0;
    logic         down_btn = 1'b0;
    logic         select_btn = 1'b0;
    logic [W-1:0] sel_index;
    logic         selection_done;
    logic         mode;
    logic         commit_pulse;
    logic [6:0]   seg_idx;

    int errors = 0;
    int checks = 0;
    int commit_count = 0;

    // Model state: raw sample history per button (bit 0 = newest), debounced
    // level, its previous value and the press pulse visible this cycle.
    logic [15:0] hist [3];
    bit          lvl [3];
    bit          lvl_prev [3];
    bit          pls [3];
    int          m_sel;
    bit          m_done;
    bit          m_mode;
    bit          m_commit;
    logic [6:0]  m_seg;

    button_menu_ctrl #(.DEBOUNCE_CYCLES(D), .NUM_OPTIONS(N)) dut (
        .clk(clk),
        .rst(rst),
        .up_btn(up_btn),
        .down_btn(down_btn),
        .select_btn(select_btn),
        .sel_index(sel_index),
        .selection_done(selection_done),
        .mode(mode),
        .commit_pulse(commit_pulse),
        .seg_idx(seg_idx)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            hist[b] = '0;
            lvl[b] = 1'b0;
            lvl_prev[b] = 1'b0;
            pls[b] = 1'b0;
        end
        m_sel = 0;
        m_done = 1'b0;
        m_mode = 1'b0;
        m_commit = 1'b0;
        m_seg = 7'h40;
    endfunction

    function automatic void model_step(input logic [2:0] raw);
        logic [D-1:0] window;
        m_seg = SEG_REF[m_sel];
        m_commit = 1'b0;
        if (!m_done) begin
            if (pls[2]) begin
                m_done = 1'b1;
                m_mode = (m_sel % 2) == 1;
                m_commit = 1'b1;
            end else if (pls[0] && !pls[1]) begin
                m_sel = (m_sel + 1) % N;
            end else if (pls[1] && !pls[0]) begin
                m_sel = (m_sel + N - 1) % N;
            end
        end else if (pls[2]) begin
            m_done = 1'b0;
        end
        // A level flips once the last D synchronized samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            pls[b] = lvl[b] && !lvl_prev[b];
            lvl_prev[b] = lvl[b];
            window = hist[b][D:1];
            if (window == '1) lvl[b] = 1'b1;
            else if (window == '0) lvl[b] = 1'b0;
            hist[b] = {hist[b][14:0], raw[b]};
        end
    endfunction

    initial model_reset();

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else model_step({select_btn, down_btn, up_btn});
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (commit_pulse) commit_count++;
        cmp("sel_index", int'(sel_index), m_sel);
        cmp("seg_idx", int'(seg_idx), int'(m_seg));
        cmp("selection_done", int'(selection_done), int'(m_done));
        cmp("mode", int'(mode), int'(m_mode));
        cmp("commit_pulse", int'(commit_pulse), int'(m_commit));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [2:0] mask, input int hold, input int idle);
        {select_btn, down_btn, up_btn} = mask;
        tick(hold);
        {select_btn, down_btn, up_btn} = 3'b000;
        tick(idle);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        int c0;
        #1 rst = 1'b0;
        tick(2);
        cmp("lit_reset_sel", int'(sel_index), 0);
        cmp("lit_reset_seg", int'(seg_idx), 7'h40);
        cmp("lit_reset_done", int'(selection_done), 0);

        // Held up: pulse after cycle 7, index moves at 8, digit follows at 9.
        rst = 1'b1;
        up_btn = 1'b1;
        tick(7);
        cmp("lit_hold_sel_c7", int'(sel_index), 0);
        tick(1);
        cmp("lit_hold_sel_c8", int'(sel_index), 1);
        cmp("lit_hold_seg_c8", int'(seg_idx), 7'h40);
        tick(1);
        cmp("lit_hold_seg_c9", int'(seg_idx), 7'h79);
        tick(11);
        up_btn = 1'b0;
        tick(12);
        cmp("lit_hold_single", int'(sel_index), 1);

        press(3'b001, 3, 12);
        cmp("lit_glitch", int'(sel_index), 1);

        do_reset();
        press(3'b010, 6, 8);
        cmp("lit_down_wrap", int'(sel_index), 3);
        repeat (4) press(3'b001, 6, 8);
        cmp("lit_up_four", int'(sel_index), 3);

        c0 = commit_count;
        press(3'b100, 6, 8);
        cmp("lit_commit_done", int'(selection_done), 1);
        cmp("lit_commit_mode", int'(mode), 1);
        cmp("lit_commit_once", commit_count - c0, 1);
        press(3'b001, 6, 8);
        cmp("lit_done_frozen", int'(sel_index), 3);
        press(3'b100, 6, 8);
        cmp("lit_release_done", int'(selection_done), 0);
        cmp("lit_release_mode", int'(mode), 1);

        press(3'b011, 6, 8);
        cmp("lit_updown", int'(sel_index), 3);
        c0 = commit_count;
        press(3'b111, 6, 8);
        cmp("lit_all_sel", int'(sel_index), 3);
        cmp("lit_all_done", int'(selection_done), 1);
        cmp("lit_all_commit", commit_count - c0, 1);

        // Reset while DONE with down mid-debounce.
        down_btn = 1'b1;
        tick(3);
        rst = 1'b0;
        #1;
        cmp("lit_rst_done", int'(selection_done), 0);
        cmp("lit_rst_mode", int'(mode), 0);
        cmp("lit_rst_seg", int'(seg_idx), 7'h40);
        down_btn = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(15);
        cmp("lit_rst_no_down", int'(sel_index), 0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                {select_btn, down_btn, up_btn} = 3'($urandom_range(0, 7));
                rst = 1'b0;
                tick($urandom_range(1, 3));
                rst = 1'b1;
            end
            press(3'($urandom_range(0, 7)), $urandom_range(1, 9), $urandom_range(0, 9));
        end
        tick(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
